boot_loader: RTL

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 20 ++
 rtl/boot_loader.sv | 115 +++++++++++
 2 files changed

// File: rtl/boot_loader_pkg.sv
// Shared CPU package: loader state encoding and machine word width.
// Imported by the loader and by the system FSM that decodes loader status.
package boot_loader_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_FETCH = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_t;

  function automatic logic ld_busy(ld_state_t s);
    return (s == LD_FETCH) || (s == LD_WRITE);
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Boot loader: copies a program from a synchronous ROM into RAM, two cycles
// per word (FETCH presents the address, WRITE consumes the ROM data).
//
// Ports:
//   clock, reset      sole clock; async active-high reset
//   start             load request (restarts from IDLE or DONE)
//   rom_addr/rom_data ROM word index out, read data in (1-cycle latency)
//   mem_write/addr/   RAM write strobe, address (BASE_ADDR+index, wraps)
//   mem_write_data    and data (ROM word passed through)
//   busy, done        copy in progress / copy completed (level)
//   word_count        words written by the current/last copy
//   checksum          mod-2^16 sum of the words written
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned PROG_WORDS = 16,
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter logic [15:0] END_MARKER = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_write_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic [15:0] checksum
);

  localparam word_t LAST_IDX = word_t'(PROG_WORDS - 1);

  ld_state_t r_state;
  ld_state_t w_next;
  word_t     r_index;
  word_t     r_count;
  word_t     r_sum;

  logic w_launch;
  logic w_marker;
  logic w_write;
  logic w_last;

  assign w_marker = (rom_data == END_MARKER);
  assign w_last   = (r_index == LAST_IDX);

  // Two-process FSM: next state and strobes, defaults first.
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_write  = 1'b0;
    unique case (r_state)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          w_launch = 1'b1;
          w_next   = LD_FETCH;
        end
      end
      LD_FETCH: begin
        w_next = LD_WRITE;
      end
      LD_WRITE: begin
        unique case (1'b1)
          w_marker: w_next = LD_DONE;
          w_last: begin
            w_write = 1'b1;
            w_next  = LD_DONE;
          end
          default: begin
            w_write = 1'b1;
            w_next  = LD_FETCH;
          end
        endcase
      end
      default: w_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_index <= '0;
      r_count <= '0;
      r_sum   <= '0;
    end else if (w_launch) begin
      r_index <= '0;
      r_count <= '0;
      r_sum   <= '0;
    end else if (w_write) begin
      r_index <= r_index + 16'd1;
      r_count <= r_count + 16'd1;
      r_sum   <= r_sum + rom_data;
    end
  end

  assign rom_addr       = r_index;
  assign mem_write      = w_write;
  assign mem_addr       = BASE_ADDR + r_index;
  assign mem_write_data = rom_data;
  assign busy           = ld_busy(r_state);
  assign done           = (r_state == LD_DONE);
  assign word_count     = r_count;
  assign checksum       = r_sum;

endmodule
